ycconfig_bank: RTL and testbench
================================

YCCONFIG_BANK -- requirements
Module: ycconfig_bank

Interface
REQ-001 Parameter NCELLS, default 4, range 1..64: number of yellow-cell configuration slots in the chain.
REQ-002 Parameter AUTOCOMMIT, default 0: 1 = active configuration loads automatically at each frame end.
REQ-003 Clock and reset: one clock, confclk; reset is synchronous and active-high, named reset.
REQ-004 confclk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high clear of all state.
REQ-006 cbitvalid  input  1  qualifies cbitin; one bit accepted per cycle when high.
REQ-007 cbitin  input  1  serial configuration bit from the previous bank or the loader.
REQ-008 commit  input  1  copies the shadow chain into the active configuration.
REQ-009 cbitout  output  1  serial bit to the next bank (MSB of the shadow chain).
REQ-010 frame_done  output  1  one-cycle pulse after 3*NCELLS bits have been accepted.
REQ-011 midframe  output  1  high while the bit counter is nonzero.
REQ-012 empty, hblock, hbypass, hmatch0, hmatch1, vblock, vbypass, vmatch0, vmatch1  output  NCELLS each  decoded per-cell controls; bit i belongs to cell i.

Function
REQ-013 Shadow chain sh is 3*NCELLS bits; cell i occupies sh[3i+2:3i], and cell 0 is nearest cbitin.
REQ-014 When cbitvalid is high, sh SHALL shift toward the MSB with cbitin entering sh[0]; when cbitvalid is low, sh holds.
REQ-015 cbitout SHALL equal sh[3*NCELLS-1], driven directly from the register; the first bit shifted in reaches cbitout after 3*NCELLS accepted bits.
REQ-016 The bit counter SHALL count accepted bits from 0 to 3*NCELLS-1 and wrap to 0 on the last bit.
REQ-017 frame_done SHALL be asserted for exactly one cycle, the cycle after the wrapping bit is accepted.
REQ-018 Active register act (3*NCELLS bits) SHALL change only on commit, on auto-commit, or on reset.
REQ-019 Decoded outputs SHALL remain stable while bits are shifting.
REQ-020 commit with cbitvalid low: act <= sh.
REQ-021 commit with cbitvalid high in the same cycle: act <= sh as it was before that cycle's shift.
REQ-022 AUTOCOMMIT=1: on the cycle the wrapping bit is accepted, act SHALL load the post-shift sh value; this load takes priority over a simultaneous commit.
REQ-023 Per-cell decode from act code {b2,b1,b0}, output order empty,hblock,hbypass,hmatch0,hmatch1,vblock,vbypass,vmatch0,vmatch1:
  - 000 -> 110001000
  - 001 -> 001000100
  - 010 -> 001001000
  - 011 -> 010000100
  - 100 -> 000000101
  - 101 -> 000000110
  - 110 -> 001010000
  - 111 -> 001100000
REQ-024 Decode SHALL be combinational from act only; it has no dependence on sh or the counter.

Reset
REQ-025 reset has the highest priority and overrides cbitvalid, commit, auto-commit and readback load.
REQ-026 On reset: sh=0, act=0, counter=0, frame_done=0, midframe=0, cbitout=0.
REQ-027 After reset every cell decodes as code 000: empty, hblock and vblock all ones; all other decoded outputs zero.
REQ-028 Reset in mid-frame SHALL discard the partial frame; the next accepted bit is bit 0 of a new frame.

Configuration
REQ-029 Macro YCCONFIG_READBACK_EN, when defined, SHALL add input rdload (1 bit).
REQ-030 On rdload: sh <= act and counter <= 0; rdload has priority over cbitvalid and commit in the same cycle. The current configuration then shifts out on cbitout as new bits are accepted.
REQ-031 Without YCCONFIG_READBACK_EN, the rdload port and its logic SHALL be absent; sh changes only by shifting or reset.

Verification (NCELLS=4, AUTOCOMMIT=0 unless stated)
REQ-032 Reset -> empty=hblock=vblock=4'b1111; every other decoded bus 4'b0000; cbitout=0; frame_done=0.
REQ-033 Shift 12 bits 001,010,011,100 (cell3 first, MSB first), then commit:
  - expect empty=0000, hblock=0010, hbypass=1100, vblock=0100, vbypass=1011, vmatch1=0001.
  - frame_done pulses once, the cycle after the 12th bit.
REQ-034 After the committed load, shift 6 bits -> all decoded outputs unchanged; midframe=1; a 12-bit frame of 1s followed by commit -> hbypass=1111, hmatch0=1111.
REQ-035 commit and the 12th cbitvalid asserted in the same cycle -> act holds the pre-shift sh.
REQ-036 Same case with AUTOCOMMIT=1 -> act holds the post-shift frame, and no separate commit is required.
REQ-037 Readback (macro defined): load frame REQ-033, commit, pulse rdload, shift 12 zeros -> cbitout emits 0,0,1,0,1,0,0,1,1,1,0,0.

Source files
------------

// File: rtl/ycconfig_bank.sv
// Yellow-cell configuration bank: a serial shadow chain with a committed active copy decoded into per-cell controls.
// Optional readback (shadow <= active, then shift out) is enabled by defining YCCONFIG_READBACK_EN.
module ycconfig_bank #(
  parameter int NCELLS     = 4,
  parameter bit AUTOCOMMIT = 1'b0
) (
  input  logic              confclk,
  input  logic              reset,
  input  logic              cbitvalid,
  input  logic              cbitin,
  input  logic              commit,
`ifdef YCCONFIG_READBACK_EN
  input  logic              rdload,
`endif
  output logic              cbitout,
  output logic              frame_done,
  output logic              midframe,
  output logic [NCELLS-1:0] empty,
  output logic [NCELLS-1:0] hblock,
  output logic [NCELLS-1:0] hbypass,
  output logic [NCELLS-1:0] hmatch0,
  output logic [NCELLS-1:0] hmatch1,
  output logic [NCELLS-1:0] vblock,
  output logic [NCELLS-1:0] vbypass,
  output logic [NCELLS-1:0] vmatch0,
  output logic [NCELLS-1:0] vmatch1
);

  localparam int NBITS = 3 * NCELLS;
  localparam int CW    = $clog2(NBITS + 1);

  logic [NBITS-1:0] sh;
  logic [NBITS-1:0] act;
  logic [NBITS-1:0] sh_shift;
  logic [CW-1:0]    cnt;
  logic             load_rd;
  logic             accept;
  logic             wrap;

`ifdef YCCONFIG_READBACK_EN
  assign load_rd = rdload;
`else
  assign load_rd = 1'b0;
`endif

  // A readback load claims the cycle, so no bit is accepted alongside it.
  assign accept   = cbitvalid && !load_rd;
  assign wrap     = accept && (cnt == CW'(NBITS - 1));
  assign sh_shift = {sh[NBITS-2:0], cbitin};

  // NOTE: every register here, including the wide shadow and active vectors, is
  // cleared by reset; they are flops, not a RAM, so clearing them costs nothing.
  always_ff @(posedge confclk) begin
    if (reset) begin
      sh         <= '0;
      act        <= '0;
      cnt        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;

      if (load_rd) begin
        sh  <= act;
        cnt <= '0;
      end else if (accept) begin
        sh  <= sh_shift;
        cnt <= wrap ? '0 : cnt + 1'b1;
      end

      // Manual commit captures the pre-shift shadow; auto-commit wins and takes the completed frame.
      if (AUTOCOMMIT && wrap) begin
        act <= sh_shift;
      end else if (commit && !load_rd) begin
        act <= sh;
      end
    end
  end

  assign cbitout  = sh[NBITS-1];
  assign midframe = (cnt != '0);

  // Order: empty,hblock,hbypass,hmatch0,hmatch1,vblock,vbypass,vmatch0,vmatch1.
  function automatic logic [8:0] decode_cell(input logic [2:0] code);
    case (code)
      3'b000:  return 9'b110001000;
      3'b001:  return 9'b001000100;
      3'b010:  return 9'b001001000;
      3'b011:  return 9'b010000100;
      3'b100:  return 9'b000000101;
      3'b101:  return 9'b000000110;
      3'b110:  return 9'b001010000;
      default: return 9'b001100000;
    endcase
  endfunction

  // NOTE: all outputs get a default before the loop so no path can infer a latch.
  always_comb begin
    empty   = '0;
    hblock  = '0;
    hbypass = '0;
    hmatch0 = '0;
    hmatch1 = '0;
    vblock  = '0;
    vbypass = '0;
    vmatch0 = '0;
    vmatch1 = '0;
    for (int i = 0; i < NCELLS; i++) begin
      {empty[i], hblock[i], hbypass[i], hmatch0[i], hmatch1[i],
       vblock[i], vbypass[i], vmatch0[i], vmatch1[i]} = decode_cell(act[3*i +: 3]);
    end
  end

endmodule

// File: tb/tb_ycconfig_bank.sv
// Directed bench for ycconfig_bank: NCELLS=4 instance with AUTOCOMMIT=0 and a twin with AUTOCOMMIT=1.
module tb_ycconfig_bank;

  logic confclk = 1'b0;
  logic reset, cbitvalid, cbitin, commit, rdload;

  logic cbitout, frame_done, midframe;
  logic [3:0] empty, hblock, hbypass, hmatch0, hmatch1, vblock, vbypass, vmatch0, vmatch1;
  logic cbitout_ac, frame_done_ac, midframe_ac;
  logic [3:0] empty_ac, hblock_ac, hbypass_ac, hmatch0_ac, hmatch1_ac;
  logic [3:0] vblock_ac, vbypass_ac, vmatch0_ac, vmatch1_ac;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 confclk = ~confclk;

  ycconfig_bank #(.NCELLS(4), .AUTOCOMMIT(1'b0)) dut (
    .confclk(confclk), .reset(reset), .cbitvalid(cbitvalid), .cbitin(cbitin), .commit(commit),
`ifdef YCCONFIG_READBACK_EN
    .rdload(rdload),
`endif
    .cbitout(cbitout), .frame_done(frame_done), .midframe(midframe),
    .empty(empty), .hblock(hblock), .hbypass(hbypass), .hmatch0(hmatch0), .hmatch1(hmatch1),
    .vblock(vblock), .vbypass(vbypass), .vmatch0(vmatch0), .vmatch1(vmatch1)
  );

  ycconfig_bank #(.NCELLS(4), .AUTOCOMMIT(1'b1)) dut_ac (
    .confclk(confclk), .reset(reset), .cbitvalid(cbitvalid), .cbitin(cbitin), .commit(commit),
`ifdef YCCONFIG_READBACK_EN
    .rdload(rdload),
`endif
    .cbitout(cbitout_ac), .frame_done(frame_done_ac), .midframe(midframe_ac),
    .empty(empty_ac), .hblock(hblock_ac), .hbypass(hbypass_ac), .hmatch0(hmatch0_ac),
    .hmatch1(hmatch1_ac), .vblock(vblock_ac), .vbypass(vbypass_ac), .vmatch0(vmatch0_ac),
    .vmatch1(vmatch1_ac)
  );

  // Decoded buses packed as empty,hblock,hbypass,hmatch0,hmatch1,vblock,vbypass,vmatch0,vmatch1.
  logic [35:0] dec, dec_ac;
  assign dec    = {empty, hblock, hbypass, hmatch0, hmatch1, vblock, vbypass, vmatch0, vmatch1};
  assign dec_ac = {empty_ac, hblock_ac, hbypass_ac, hmatch0_ac, hmatch1_ac,
                   vblock_ac, vbypass_ac, vmatch0_ac, vmatch1_ac};

  localparam logic [35:0] DEC_RESET =
    {4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
  // Cells 3..0 = 001,010,011,100.
  localparam logic [35:0] DEC_F1 =
    {4'b0000, 4'b0010, 4'b1100, 4'b0000, 4'b0000, 4'b0100, 4'b1011, 4'b0000, 4'b0001};
  // Every cell 111.
  localparam logic [35:0] DEC_ONES =
    {4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
  // Cell 3 = 011, cells 2..0 = 111.
  localparam logic [35:0] DEC_PRE =
    {4'b0000, 4'b1000, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
  localparam logic [11:0] FRAME_F1 = 12'b001_010_011_100;

  // Drive one cycle of inputs at the falling edge; return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic b, input logic c);
    @(negedge confclk);
    cbitvalid = v;
    cbitin    = b;
    commit    = c;
    @(posedge confclk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b1, 1'b1);  // reset must override shifting and commit
    reset = 1'b0;
    n_checks++;
    if (dec !== DEC_RESET) $display("FAIL reset_decode: got %h expected %h", dec, DEC_RESET);
    else n_pass++;
    n_checks++;
    if (dec_ac !== DEC_RESET) $display("FAIL reset_decode_ac: got %h expected %h", dec_ac, DEC_RESET);
    else n_pass++;
    n_checks++;
    if ({cbitout, frame_done, midframe} !== 3'b000)
      $display("FAIL reset_flags: got %b expected 000", {cbitout, frame_done, midframe});
    else n_pass++;
  endtask

  task automatic test_shift_commit();
    int early = 0;
    for (int i = 11; i >= 0; i--) begin
      drive(1'b1, FRAME_F1[i], 1'b0);
      if (i != 0 && frame_done === 1'b1) early++;
    end
    n_checks++;
    if (early !== 0) $display("FAIL frame_done_early: got %0d pulses expected 0", early);
    else n_pass++;
    n_checks++;
    if ({frame_done, midframe} !== 2'b10)
      $display("FAIL frame_done_pulse: got %b expected 10", {frame_done, midframe});
    else n_pass++;
    n_checks++;
    if (dec !== DEC_RESET) $display("FAIL act_before_commit: got %h expected %h", dec, DEC_RESET);
    else n_pass++;
    n_checks++;
    if (dec_ac !== DEC_F1) $display("FAIL autocommit_frame: got %h expected %h", dec_ac, DEC_F1);
    else n_pass++;
    drive(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dec !== DEC_F1) $display("FAIL commit_f1: got %h expected %h", dec, DEC_F1);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL frame_done_one_cycle: got %b expected 0", frame_done);
    else n_pass++;
  endtask

  task automatic test_hold_while_shifting();
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (dec !== DEC_F1) $display("FAIL hold_decode: got %h expected %h", dec, DEC_F1);
    else n_pass++;
    n_checks++;
    if (midframe !== 1'b1) $display("FAIL midframe_high: got %b expected 1", midframe);
    else n_pass++;
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (dec !== DEC_ONES) $display("FAIL commit_ones: got %h expected %h", dec, DEC_ONES);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int early = 0;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    do_reset();
    n_checks++;
    if ({midframe, cbitout} !== 2'b00)
      $display("FAIL midframe_reset: got %b expected 00", {midframe, cbitout});
    else n_pass++;
    n_checks++;
    if (dec !== DEC_RESET) $display("FAIL midframe_reset_decode: got %h expected %h", dec, DEC_RESET);
    else n_pass++;
    for (int i = 11; i >= 0; i--) begin
      drive(1'b1, FRAME_F1[i], 1'b0);
      if (i != 0 && frame_done === 1'b1) early++;
    end
    n_checks++;
    if ({early[3:0], frame_done} !== 5'b0000_1)
      $display("FAIL new_frame_after_reset: got early=%0d done=%b expected early=0 done=1",
               early, frame_done);
    else n_pass++;
  endtask

  // Shadow holds F1 with counter at 0; eleven 1s then a 12th 1 together with commit.
  task automatic test_commit_same_cycle();
    for (int i = 0; i < 11; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    n_checks++;
    if (dec !== DEC_PRE) $display("FAIL commit_pre_shift: got %h expected %h", dec, DEC_PRE);
    else n_pass++;
    n_checks++;
    if (dec_ac !== DEC_ONES) $display("FAIL autocommit_priority: got %h expected %h", dec_ac, DEC_ONES);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b1) $display("FAIL frame_done_commit: got %b expected 1", frame_done);
    else n_pass++;
  endtask

  task automatic test_cbitout();
    do_reset();
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (cbitout !== 1'b0) $display("FAIL cbitout_11: got %b expected 0", cbitout);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (cbitout !== 1'b1) $display("FAIL cbitout_12: got %b expected 1", cbitout);
    else n_pass++;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++;
    if (cbitout !== 1'b1) $display("FAIL cbitout_hold: got %b expected 1", cbitout);
    else n_pass++;
    drive(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (cbitout !== 1'b0) $display("FAIL cbitout_next: got %b expected 0", cbitout);
    else n_pass++;
  endtask

`ifdef YCCONFIG_READBACK_EN
  task automatic test_readback();
    logic [11:0] seen = '0;
    do_reset();
    for (int i = 11; i >= 0; i--) drive(1'b1, FRAME_F1[i], 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    rdload = 1'b1;
    drive(1'b1, 1'b1, 1'b0);  // the simultaneous bit must be ignored
    rdload = 1'b0;
    n_checks++;
    if (midframe !== 1'b0) $display("FAIL readback_counter: got %b expected 0", midframe);
    else n_pass++;
    for (int i = 11; i >= 0; i--) begin
      seen[i] = cbitout;
      drive(1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (seen !== FRAME_F1) $display("FAIL readback_stream: got %b expected %b", seen, FRAME_F1);
    else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  initial begin
    reset     = 1'b0;
    cbitvalid = 1'b0;
    cbitin    = 1'b0;
    commit    = 1'b0;
    rdload    = 1'b0;
    test_reset();
    test_shift_commit();
    test_hold_while_shifting();
    test_reset_midframe();
    test_commit_same_cycle();
    test_cbitout();
`ifdef YCCONFIG_READBACK_EN
    test_readback();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
